// File: rtl/dfr_readout_mac_if.sv
// Node stream, weight RAM read port and result port of the DFR readout MAC.
// The master side feeds nodes/weights and consumes results; the MAC is the slave.
interface dfr_readout_mac_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_OUTPUTS = 1,
  parameter int NODE_IDX_W  = 7
);
  logic                              clear;
  logic [NODE_IDX_W:0]               cfg_num_nodes;
  logic [5:0]                        cfg_frac_bits;
  logic                              node_valid;
  logic                              node_ready;
  logic [DATA_WIDTH-1:0]             node_data;
  logic                              weight_rd_en;
  logic [NODE_IDX_W-1:0]             weight_addr;
  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] weight_rdata;
  logic                              out_valid;
  logic                              out_ready;
  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data;
  logic [NUM_OUTPUTS-1:0]            out_sat;
  logic                              busy;
  logic [31:0]                       sample_cnt;

  modport master (
    output clear, cfg_num_nodes, cfg_frac_bits, node_valid, node_data,
           weight_rdata, out_ready,
    input  node_ready, weight_rd_en, weight_addr, out_valid, out_data,
           out_sat, busy, sample_cnt
  );

  modport slave (
    input  clear, cfg_num_nodes, cfg_frac_bits, node_valid, node_data,
           weight_rdata, out_ready,
    output node_ready, weight_rd_en, weight_addr, out_valid, out_data,
           out_sat, busy, sample_cnt
  );
endinterface

// File: rtl/dfr_readout_mac.sv
// Streaming DFR readout: multiply-accumulates node states against per-node
// weights on NUM_OUTPUTS channels and emits saturated fixed-point results.
module dfr_readout_mac #(
  parameter int DATA_WIDTH        = 32,
  parameter int NUM_VIRTUAL_NODES = 100,
  parameter int NUM_OUTPUTS       = 1,
  parameter int ACC_WIDTH         = 2*DATA_WIDTH+8,
  parameter int NODE_IDX_W        = $clog2(NUM_VIRTUAL_NODES)
) (
  input logic              S_AXI_ACLK,
  input logic              S_AXI_ARESETN,
  dfr_readout_mac_if.slave bus
);
  localparam int PROD_W = 2*DATA_WIDTH;
  localparam logic [NODE_IDX_W:0] MAX_NODES = (NODE_IDX_W+1)'(NUM_VIRTUAL_NODES);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ACCUM, DRAIN, OUT} state_t;

  state_t                 state_q, state_d;
  logic [NODE_IDX_W-1:0]  idx_q, idx_d;
  logic [NODE_IDX_W:0]    num_q, num_d;
  logic [DATA_WIDTH-1:0]  node_q, node_d;
  logic                   mac_q, mac_d;
  logic [31:0]            cnt_q, cnt_d;
  logic                   beat;
  logic                   out_hs;
  logic                   last_beat;
  logic [NODE_IDX_W:0]    cfg_eff;
  logic [NODE_IDX_W:0]    num_eff;

  // The node count is only taken from cfg on the first beat of a sample.
  always_comb begin
    cfg_eff = (bus.cfg_num_nodes == '0 || bus.cfg_num_nodes > MAX_NODES)
              ? MAX_NODES : bus.cfg_num_nodes;
    num_eff = (idx_q == '0) ? cfg_eff : num_q;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    num_d     = num_q;
    node_d    = node_q;
    mac_d     = 1'b0;
    cnt_d     = cnt_q;
    bus.node_ready = (state_q == ACCUM);
    beat      = bus.node_valid && (state_q == ACCUM) && !bus.clear;
    out_hs    = (state_q == OUT) && bus.out_ready;
    last_beat = (({1'b0, idx_q} + (NODE_IDX_W+1)'(1)) == num_eff);

    unique case (state_q)
      ACCUM: begin
        if (beat) begin
          node_d = bus.node_data;
          mac_d  = 1'b1;
          idx_d  = idx_q + NODE_IDX_W'(1);
          if (idx_q == '0) num_d = cfg_eff;
          if (last_beat) state_d = DRAIN;
        end
      end
      DRAIN: state_d = OUT;
      OUT: begin
        if (bus.out_ready) begin
          state_d = ACCUM;
          idx_d   = '0;
          cnt_d   = cnt_q + 32'd1;
        end
      end
      default: state_d = ACCUM;
    endcase

    if (bus.clear) begin
      state_d = ACCUM;
      idx_d   = '0;
      mac_d   = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      num_q   <= '0;
      node_q  <= '0;
      mac_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      node_q  <= node_d;
      mac_q   <= mac_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.weight_rd_en = beat;
  assign bus.weight_addr  = idx_q;
  assign bus.out_valid    = (state_q == OUT);
  assign bus.busy         = (state_q != ACCUM) || (idx_q != '0);
  assign bus.sample_cnt   = cnt_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_ch
      logic [DATA_WIDTH-1:0]       w;
      logic signed [PROD_W-1:0]    prod;
      logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
      logic signed [ACC_WIDTH-1:0] shifted;
      logic [DATA_WIDTH-1:0]       res;
      logic                        sat;

      assign w    = bus.weight_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
      // Operands sign-extended to the product width so the low half is the exact signed product.
      assign prod = {{DATA_WIDTH{node_q[DATA_WIDTH-1]}}, node_q} *
                    {{DATA_WIDTH{w[DATA_WIDTH-1]}}, w};

      always_comb begin
        acc_d = acc_q;
        if (bus.clear || out_hs) acc_d = '0;
        else if (mac_q) acc_d = acc_q + {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
      end

      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) acc_q <= '0;
        else                acc_q <= acc_d;
      end

      always_comb begin
        shifted = acc_q >>> bus.cfg_frac_bits;
        res     = shifted[DATA_WIDTH-1:0];
        sat     = 1'b0;
        if (shifted > SAT_MAX) begin
          res = SAT_MAX[DATA_WIDTH-1:0];
          sat = 1'b1;
        end else if (shifted < SAT_MIN) begin
          res = SAT_MIN[DATA_WIDTH-1:0];
          sat = 1'b1;
        end
      end

      assign bus.out_data[gi*DATA_WIDTH +: DATA_WIDTH] = res;
      assign bus.out_sat[gi] = sat;
    end
  endgenerate
endmodule

// File: tb/tb_dfr_readout_mac.sv
// Directed and randomized bench for dfr_readout_mac with two output channels,
// a registered-read weight RAM model and an arithmetic reference model.
module tb_dfr_readout_mac;
  localparam int DW  = 32;
  localparam int NO  = 2;
  localparam int NVN = 100;
  localparam int IW  = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dfr_readout_mac_if #(.DATA_WIDTH(DW), .NUM_OUTPUTS(NO), .NODE_IDX_W(IW)) bus ();

  dfr_readout_mac #(
    .DATA_WIDTH(DW), .NUM_VIRTUAL_NODES(NVN), .NUM_OUTPUTS(NO)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .bus(bus)
  );

  logic [DW-1:0] wmem0 [128];
  logic [DW-1:0] wmem1 [128];
  logic [DW-1:0] node_vals [128];

  // Weight RAM: data appears one cycle after the read strobe.
  always @(posedge clk)
    if (bus.weight_rd_en)
      bus.weight_rdata <= {wmem1[bus.weight_addr], wmem0[bus.weight_addr]};

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  int cur_n = 0;
  logic [DW-1:0] exp_data [NO];
  logic          exp_sat  [NO];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int eff_n(input int c);
    return (c == 0 || c > NVN) ? NVN : c;
  endfunction

  function automatic logic [DW-1:0] rnd_val();
    logic signed [DW-1:0] v;
    v = $signed($urandom);
    return v >>> $urandom_range(0, 24);
  endfunction

  task automatic fill(input int n, input int mode, input logic [DW-1:0] nv,
                      input logic [DW-1:0] w0, input logic [DW-1:0] w1);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: begin node_vals[i] = nv; wmem0[i] = w0; wmem1[i] = w1; end
        1: begin node_vals[i] = DW'(i); wmem0[i] = 1; wmem1[i] = 1; end
        default: begin node_vals[i] = rnd_val(); wmem0[i] = rnd_val(); wmem1[i] = rnd_val(); end
      endcase
    end
  endtask

  // Sum of node*weight over the sample, scaled and clamped to DW bits.
  task automatic compute_model(input int frac);
    logic signed [79:0] sum;
    logic signed [DW-1:0] a, b;
    for (int ch = 0; ch < NO; ch++) begin
      sum = '0;
      for (int i = 0; i < cur_n; i++) begin
        a = $signed(node_vals[i]);
        b = (ch == 0) ? $signed(wmem0[i]) : $signed(wmem1[i]);
        sum = sum + a * b;
      end
      sum = sum >>> frac;
      exp_sat[ch] = 1'b1;
      if (sum > 80'sh7FFFFFFF)            exp_data[ch] = 32'h7FFFFFFF;
      else if (sum < -(80'sh80000000))    exp_data[ch] = 32'h80000000;
      else begin exp_data[ch] = sum[DW-1:0]; exp_sat[ch] = 1'b0; end
    end
  endtask

  task automatic send_beats(input int ncfg, input bit gaps, input bit chk_stream, input bit scramble);
    logic [31:0] r;
    cur_n = eff_n(ncfg);
    bus.cfg_num_nodes = ncfg[IW:0];
    for (int i = 0; i < cur_n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.node_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.node_valid = 1'b1;
      bus.node_data  = node_vals[i];
      if (chk_stream) begin
        #1;
        check($sformatf("stream_rd_en[%0d]", i), bus.weight_rd_en, 1);
        check($sformatf("stream_addr[%0d]", i), bus.weight_addr, i);
        check($sformatf("stream_ready[%0d]", i), bus.node_ready, 1);
      end
      @(posedge clk); #1;
      if (scramble && i == 0) begin
        r = $urandom;
        bus.cfg_num_nodes = r[IW:0];
      end
    end
    bus.node_valid = 1'b0;
    check("drain_out_valid", bus.out_valid, 0);
    check("drain_node_ready", bus.node_ready, 0);
  endtask

  task automatic wait_result();
    int waited;
    waited = 0;
    while (bus.out_valid !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("out_latency", waited, 1);
  endtask

  task automatic check_result(input int frac);
    compute_model(frac);
    for (int ch = 0; ch < NO; ch++) begin
      check($sformatf("out_data[%0d]", ch), bus.out_data[ch*DW +: DW], exp_data[ch]);
      check($sformatf("out_sat[%0d]", ch), bus.out_sat[ch], exp_sat[ch]);
    end
  endtask

  task automatic ack(input int hold);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.out_valid, 1);
      check("hold_data0", bus.out_data[DW-1:0], exp_data[0]);
      check("hold_data1", bus.out_data[2*DW-1:DW], exp_data[1]);
      check("hold_node_ready", bus.node_ready, 0);
      check("hold_busy", bus.busy, 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    exp_cnt++;
    check("ack_out_valid", bus.out_valid, 0);
    check("ack_node_ready", bus.node_ready, 1);
    check("ack_busy", bus.busy, 0);
    check("sample_cnt", bus.sample_cnt, exp_cnt);
  endtask

  task automatic full_sample(input int ncfg, input int frac, input bit gaps, input int hold);
    bus.cfg_frac_bits = 6'(frac);
    send_beats(ncfg, gaps, 1'b0, gaps);
    wait_result();
    check_result(frac);
    ack(hold);
  endtask

  initial begin
    bus.clear = 1'b0;
    bus.node_valid = 1'b0;
    bus.node_data = '0;
    bus.out_ready = 1'b0;
    bus.cfg_num_nodes = 8'd4;
    bus.cfg_frac_bits = 6'd0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_node_ready", bus.node_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_rd_en", bus.weight_rd_en, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_sat", bus.out_sat, 0);
    check("rst_sample_cnt", bus.sample_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Two-channel basic fixed-point result
    fill(4, 0, 32'h00010000, 32'h00008000, 32'hFFFE0000);
    bus.cfg_frac_bits = 6'd16;
    send_beats(4, 1'b0, 1'b0, 1'b0);
    wait_result();
    check("basic_ch0", bus.out_data[DW-1:0], 32'h00020000);
    check("basic_ch1", bus.out_data[2*DW-1:DW], 32'hFFF80000);
    check("basic_sat", bus.out_sat, 2'b00);
    check_result(16);
    ack(0);

    // Saturation on both rails
    fill(4, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000001);
    bus.cfg_frac_bits = 6'd0;
    send_beats(4, 1'b0, 1'b0, 1'b0);
    wait_result();
    check("sat_ch0", bus.out_data[DW-1:0], 32'h7FFFFFFF);
    check("sat_ch1", bus.out_data[2*DW-1:DW], 32'h80000000);
    check("sat_flags", bus.out_sat, 2'b11);
    check_result(0);
    ack(0);

    // Default length, full throughput, then backpressure
    fill(NVN, 1, '0, '0, '0);
    bus.cfg_frac_bits = 6'd0;
    send_beats(0, 1'b0, 1'b1, 1'b0);
    wait_result();
    check("ramp_ch0", bus.out_data[DW-1:0], 4950);
    check("ramp_ch1", bus.out_data[2*DW-1:DW], 4950);
    check_result(0);
    ack(5);
    fill(4, 2, '0, '0, '0);
    full_sample(4, 8, 1'b0, 0);

    // Randomized samples, with gaps and cfg_num_nodes disturbed mid-sample
    for (int t = 0; t < 12; t++) begin
      int nc;
      nc = (t == 0) ? 1 : (t == 1) ? 0 : (t == 2) ? 120 : $urandom_range(1, 127);
      fill(eff_n(nc), 2, '0, '0, '0);
      full_sample(nc, $urandom_range(0, 40), 1'b1, $urandom_range(0, 2));
    end

    // Clear concurrent with beat 51 of 100
    fill(NVN, 2, '0, '0, '0);
    bus.cfg_num_nodes = '0;
    for (int i = 0; i < 50; i++) begin
      bus.node_valid = 1'b1;
      bus.node_data = node_vals[i];
      @(posedge clk); #1;
    end
    bus.clear = 1'b1;
    bus.node_data = node_vals[50];
    @(posedge clk); #1;
    bus.clear = 1'b0;
    bus.node_valid = 1'b0;
    check("clr_busy", bus.busy, 0);
    check("clr_node_ready", bus.node_ready, 1);
    check("clr_idx", bus.weight_addr, 0);
    check("clr_out_valid", bus.out_valid, 0);
    check("clr_sample_cnt", bus.sample_cnt, exp_cnt);
    fill(4, 2, '0, '0, '0);
    full_sample(4, 4, 1'b0, 0);

    // Asynchronous reset while in DRAIN
    fill(4, 2, '0, '0, '0);
    send_beats(4, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_node_ready", bus.node_ready, 1);
    check("arst_busy", bus.busy, 0);
    check("arst_sample_cnt", bus.sample_cnt, 0);
    exp_cnt = 0;
    @(posedge clk); #1;
    check("arst_held_valid", bus.out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_node_ready", bus.node_ready, 1);
    check("rel_out_valid", bus.out_valid, 0);
    fill(7, 2, '0, '0, '0);
    full_sample(7, 2, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dfr_readout_mac.md
Name: dfr_readout_mac

Overview:
Streaming readout layer for the DFR core. It consumes reservoir node states one per beat and multiply-accumulates each against a per-node weight word fetched from the external weight RAM. After a programmable number of nodes it emits NUM_OUTPUTS fixed-point results. It is the parametrised successor of the single-output readout: node count, data width, output channel count and fraction point are all configurable, and results are saturated.

Parameters:
DATA_WIDTH, 32, signed width of node states, weights and outputs
NUM_VIRTUAL_NODES, 100, maximum nodes per sample (1..256)
NUM_OUTPUTS, 1, parallel output channels sharing one node stream
ACC_WIDTH, 2*DATA_WIDTH+8, signed accumulator width; no wrap for up to 256 nodes
NODE_IDX_W, $clog2(NUM_VIRTUAL_NODES), width of node index and weight address

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
clear  in  1  synchronous abort; returns block to empty sample
cfg_num_nodes  in  NODE_IDX_W+1  nodes per sample; 0 or >NUM_VIRTUAL_NODES means NUM_VIRTUAL_NODES
cfg_frac_bits  in  6  arithmetic right shift applied to the accumulator before output
node_valid  in  1  node state beat valid
node_ready  out  1  block accepts a node beat
node_data  in  DATA_WIDTH  signed node state
weight_rd_en  out  1  weight RAM read strobe
weight_addr  out  NODE_IDX_W  weight RAM address = node index
weight_rdata  in  NUM_OUTPUTS*DATA_WIDTH  weights, channel k in bits [k*DATA_WIDTH +: DATA_WIDTH]; valid 1 cycle after weight_rd_en
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_data  out  NUM_OUTPUTS*DATA_WIDTH  saturated results, same packing as weight_rdata
out_sat  out  NUM_OUTPUTS  per-channel saturation flag for the current result
busy  out  1  a sample is partially accumulated or its result is pending
sample_cnt  out  32  completed result handshakes; wraps at 2^32

Behaviour:
- Reset: state ACCUM, accumulators=0, idx=0, sample_cnt=0, and the following outputs low: out_valid, weight_rd_en, busy, out_sat. node_ready=1. out_data=0.
- States: ACCUM, DRAIN, OUT.
- ACCUM: node_ready=1. On a handshake:
  - weight_rd_en=1 and weight_addr=idx in that same cycle, driven combinationally from the handshake.
  - node_data is registered.
  - idx increments.
  - On the first beat (idx==0), cfg_num_nodes is latched as N; it is ignored for the rest of the sample.
- MAC pipeline: in the cycle after a handshake, each channel computes acc_k += sext(node_reg * w_k). The product is a full 2*DATA_WIDTH signed result. Back-to-back beats sustain 1 node/cycle.
- Last beat (idx==N-1) handshake at edge E: state goes to DRAIN and node_ready drops. At E+1 the final product is accumulated and state goes to OUT. out_valid is high from E+1.
- OUT:
  - out_data_k = sat(acc_k >>> cfg_frac_bits), clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - out_sat_k=1 when clamping occurred.
  - out_data is combinational from the accumulators and cfg_frac_bits. cfg_frac_bits must be held stable while out_valid=1.
  - out_valid and out_data are held until out_ready.
  - On the out_valid&out_ready edge: accumulators=0, idx=0, sample_cnt++, state goes to ACCUM, and node_ready=1 in the next cycle.
- busy = (state!=ACCUM) || (idx!=0).
- clear has priority over all events. The next cycle is equivalent to post-reset except that sample_cnt is kept. Any in-flight product is discarded. A handshake in the same cycle as clear is dropped.
- An asynchronous reset mid-sample discards all state immediately.
- N=1: DRAIN is entered on the first beat.

Test Plan:
- Basic, 2 channels: NUM_OUTPUTS=2, cfg_num_nodes=4, cfg_frac_bits=16, 4 nodes of 0x00010000, weights ch0=0x00008000 and ch1=0xFFFE0000 -> out_data ch0=0x00020000, ch1=0xFFF80000; out_sat=0; out_valid rises 2 cycles after the last handshake cycle; sample_cnt=1.
- Saturation: cfg_num_nodes=4, cfg_frac_bits=0, nodes=0x7FFFFFFF, ch0 weights=0x7FFFFFFF, ch1 weights=0x80000001 -> ch0=0x7FFFFFFF with out_sat[0]=1; ch1=0x80000000 with out_sat[1]=1.
- Throughput and default length: cfg_num_nodes=0, 100 continuous beats with node=i and weight=1, frac=0 -> out_data=4950; weight_addr steps 0..99 on consecutive cycles; node_ready is never deasserted during the sample.
- Backpressure: out_ready held low for 5 cycles after out_valid -> out_valid and out_data are stable, node_ready=0, busy=1. Then out_ready=1 for one cycle -> node_ready=1 on the next cycle and the accumulator is cleared (the next sample's result is independent).
- clear mid-sample: after 50 of 100 beats assert clear concurrently with a beat -> that beat is dropped, idx=0, busy=0 next cycle; a fresh 4-node sample then gives the correct result.
- Reset: S_AXI_ARESETN low during DRAIN -> out_valid=0, sample_cnt=0, node_ready=1 immediately after release.
